// File: rtl/sobel_read_sequencer_pkg.sv
// Shared types and address-bound helper for the Sobel read sequencer.
package sobel_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  typedef logic [1:0] tap_idx_t;

  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] last_addr;
  } addr_bounds_t;

  // First base sits TAPS-1 rows down so the oldest tap never goes below word 0;
  // the last base is the final word of the frame.
  function automatic addr_bounds_t calc_bounds(input int row_len, input int img_height,
                                               input int taps);
    addr_bounds_t b;
    b.start_addr = 32'((taps - 1) * row_len);
    b.last_addr  = 32'(img_height * row_len - 1);
    return b;
  endfunction

endpackage

// File: rtl/sobel_read_sequencer_if.sv
// Handshake bundle between the read sequencer (master) and the filter side (slave).
interface sobel_read_sequencer_if #(
  parameter int ADDR_W = 20,
  parameter int COL_W  = 8
);
  import sobel_seq_pkg::*;

  logic              start;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  tap_idx_t          tap_idx;
  logic              tap_valid;
  logic [COL_W-1:0]  col_pos;
  logic              busy;
  logic              done;

  modport master (
    input  start, rd_ready,
    output rd_addr, rd_valid, tap_idx, tap_valid, col_pos, busy, done
  );

  modport slave (
    output start, rd_ready,
    input  rd_addr, rd_valid, tap_idx, tap_valid, col_pos, busy, done
  );

endinterface

// File: rtl/sobel_read_sequencer_tap_delay.sv
// RD_LAT-deep {valid, idx} shift register that lines tap tags up with SRAM read data.
module sobel_tap_delay
  import sobel_seq_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     clear,
  input  logic     in_valid,
  input  tap_idx_t in_idx,
  output logic     out_valid,
  output tap_idx_t out_idx,
  output logic     empty
);

  logic [RD_LAT-1:0] vld_q;
  tap_idx_t          idx_q [RD_LAT];

  // Shift one stage per cycle; invalid slots carry idx 0 so the output stays clean.
  always_ff @(posedge clk) begin
    if (clear) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      idx_q[0] <= in_valid ? in_idx : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_idx   = idx_q[RD_LAT-1];
  assign empty     = ~|vld_q;

endmodule

// File: rtl/sobel_read_sequencer.sv
// Sobel read-address scheduler: walks every output pixel and issues TAPS reads
// up one column (newest row first), tagging returned words with their tap index.
// Optional build macro SOBEL_SEQ_PERF_EN adds issue_cnt / stall_cnt outputs.
//
//   state | meaning
//   IDLE  | waiting for start; base parked at the first pixel
//   FETCH | presenting base - k*ROW_LEN, advancing on rd_ready
//   DRAIN | last issue accepted; waiting for the tag pipeline to empty
module sobel_read_sequencer
  import sobel_seq_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int ROW_LEN    = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int TAPS       = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef SOBEL_SEQ_PERF_EN
  output logic [31:0]           issue_cnt,
  output logic [31:0]           stall_cnt,
`endif
  sobel_read_sequencer_if.master bus
);

  localparam int           COL_W      = $clog2(ROW_LEN);
  localparam addr_bounds_t BOUNDS     = calc_bounds(ROW_LEN, IMG_HEIGHT, TAPS);
  localparam logic [ADDR_W-1:0] START_ADDR = BOUNDS.start_addr[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR  = BOUNDS.last_addr[ADDR_W-1:0];
  localparam tap_idx_t     LAST_TAP   = tap_idx_t'(TAPS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  tap_idx_t          k;
  logic [ADDR_W-1:0] offset;
  logic              issuing, busy_now, done_now, start_acc;
  logic              accept, last_tap, last_issue;
  logic              pipe_empty;

  assign accept     = issuing & bus.rd_ready;
  assign last_tap   = (k == LAST_TAP);
  assign last_issue = accept & last_tap & (base == LAST_ADDR);
  // ROW_LEN is a power of two, so k*ROW_LEN is a plain shift.
  assign offset     = ADDR_W'(k) << COL_W;

  // State register; reset takes priority over a coincident start.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    issuing   = 1'b0;
    busy_now  = 1'b0;
    done_now  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        issuing  = 1'b1;
        busy_now = 1'b1;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_now = 1'b1;
        if (pipe_empty) begin
          done_now  = 1'b1;
          busy_now  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Base/tap counters: only an accepted issue advances; the last pixel parks base again.
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      base <= START_ADDR;
      k    <= '0;
    end else if (accept) begin
      if (last_tap) begin
        k    <= '0;
        base <= last_issue ? START_ADDR : base + 1'b1;
      end else begin
        k <= k + tap_idx_t'(1);
      end
    end
  end

  sobel_tap_delay #(.RD_LAT(RD_LAT)) u_tap_delay (
    .clk       (clk),
    .clear     (reset),
    .in_valid  (accept),
    .in_idx    (k),
    .out_valid (bus.tap_valid),
    .out_idx   (bus.tap_idx),
    .empty     (pipe_empty)
  );

  assign bus.rd_valid = issuing;
  assign bus.rd_addr  = issuing ? (base - offset) : '0;
  assign bus.col_pos  = base[COL_W-1:0];
  assign bus.busy     = busy_now;
  assign bus.done     = done_now;

`ifdef SOBEL_SEQ_PERF_EN
  // Saturating performance counters, cleared per pass.
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && (issue_cnt != '1)) issue_cnt <= issue_cnt + 1'b1;
      if (issuing && !bus.rd_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_read_sequencer.sv
// Scoreboard bench for sobel_read_sequencer (ROW_LEN=8, IMG_HEIGHT=6, TAPS=4, RD_LAT=1).
module tb_sobel_read_sequencer;
  import sobel_seq_pkg::*;

  localparam int ADDR_W     = 20;
  localparam int ROW_LEN    = 8;
  localparam int IMG_HEIGHT = 6;
  localparam int TAPS       = 4;
  localparam int RD_LAT     = 1;
  localparam int COL_W      = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sobel_read_sequencer_if #(.ADDR_W(ADDR_W), .COL_W(COL_W)) bus ();

`ifdef SOBEL_SEQ_PERF_EN
  logic [31:0] issue_cnt, stall_cnt;
`endif

  sobel_read_sequencer #(
    .ADDR_W(ADDR_W), .ROW_LEN(ROW_LEN), .IMG_HEIGHT(IMG_HEIGHT),
    .TAPS(TAPS), .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SOBEL_SEQ_PERF_EN
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  typedef struct {
    int addr;
    int col;
  } issue_t;

  issue_t exp_issue_q[$];
  int     exp_tap_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     pass_active = 1'b0;
  bit     done_seen = 1'b0;
  bit     prev_acc = 1'b0;
  int     issue_seen = 0;
  int     last_acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected issues/tags whenever the DUT presents them.
  always @(negedge clk) begin
    bit acc;
    issue_t e;
    if (reset) begin
      prev_acc = 1'b0;
    end else begin
      acc = bus.rd_valid && bus.rd_ready;
      if (pass_active || bus.tap_valid) chk("tap_align", bus.tap_valid, prev_acc);
      if (bus.tap_valid) begin
        chk("tap_q_avail", exp_tap_q.size() > 0, 1);
        if (exp_tap_q.size() > 0) chk("tap_idx", bus.tap_idx, exp_tap_q.pop_front());
      end
      if (acc) begin
        chk("issue_q_avail", exp_issue_q.size() > 0, 1);
        if (exp_issue_q.size() > 0) begin
          e = exp_issue_q.pop_front();
          chk("rd_addr", bus.rd_addr, e.addr);
          chk("col_pos", bus.col_pos, e.col);
          issue_seen++;
          if (exp_issue_q.size() == 0) last_acc_cyc = cyc;
        end
      end
      if (bus.done) begin
        chk("done_expected", pass_active, 1);
        if (pass_active) begin
          chk("done_latency", cyc - last_acc_cyc, 2);
          chk("busy_at_done", bus.busy, 0);
          chk("issue_total", issue_seen, 96);
          chk("issue_q_left", exp_issue_q.size(), 0);
          pass_active = 1'b0;
          done_seen   = 1'b1;
        end
      end
      prev_acc = acc;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_valid"},  bus.rd_valid, 0);
    chk({tag, "_rd_addr"},   bus.rd_addr, 0);
    chk({tag, "_tap_valid"}, bus.tap_valid, 0);
    chk({tag, "_tap_idx"},   bus.tap_idx, 0);
    chk({tag, "_col_pos"},   bus.col_pos, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_done"},      bus.done, 0);
  endtask

  // Expected pass: bases 24..47, four taps each, addr = base - 8*k.
  task automatic start_pass();
    issue_t e;
    exp_issue_q.delete();
    exp_tap_q.delete();
    for (int b = 24; b <= 47; b++) begin
      for (int k = 0; k < 4; k++) begin
        e.addr = b - 8 * k;
        e.col  = b % 8;
        exp_issue_q.push_back(e);
        exp_tap_q.push_back(k);
      end
    end
    issue_seen  = 0;
    done_seen   = 1'b0;
    pass_active = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("first_addr", bus.rd_addr, 24);
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_issue(input int addr, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (bus.rd_valid && bus.rd_addr == addr[ADDR_W-1:0]) return;
    end
    chk("wait_issue_timeout", 0, addr);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (done_seen) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rd_ready = 1'b1;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Full pass with a start pulse during FETCH that must be ignored.
    start_pass();
    repeat (8) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(400);

    // Stall three cycles on base 26, k=2 (addr 10), then check the row wrap.
    start_pass();
    wait_issue(10, 100);
    bus.rd_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall_addr", bus.rd_addr, 10);
      chk("stall_valid", bus.rd_valid, 1);
      if (j > 0) chk("stall_tap_valid", bus.tap_valid, 0);
      @(posedge clk); #1;
    end
    bus.rd_ready = 1'b1;
    @(negedge clk);
    chk("post_stall_tap_valid", bus.tap_valid, 0);
    wait_issue(32, 100);
    @(negedge clk);
    chk("wrap_col_pos", bus.col_pos, 0);
    wait_done(400);
`ifdef SOBEL_SEQ_PERF_EN
    chk("perf_issue_cnt", issue_cnt, 96);
    chk("perf_stall_cnt", stall_cnt, 3);
`endif

    // Reset in FETCH at base 30 aborts without a done.
    start_pass();
    wait_issue(30, 100);
    reset = 1'b1;
    pass_active = 1'b0;
    exp_issue_q.delete();
    exp_tap_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
`ifdef SOBEL_SEQ_PERF_EN
    chk("abort_issue_cnt", issue_cnt, 0);
`endif
    repeat (5) @(posedge clk);
    chk("no_done_after_abort", done_seen, 0);

    // start coincident with reset: reset wins.
    #1;
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_with_reset_busy", bus.busy, 0);
    chk("start_with_reset_valid", bus.rd_valid, 0);

    // Fresh pass after the abort restarts at the first pixel.
    @(posedge clk); #1;
    start_pass();
    wait_done(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
